// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - iterative IEEE-754 divider, one restoring-division quotient bit per clock
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in1,
  input  logic [EXP_W+MAN_W:0] in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out,
  output logic                 flag_invalid,
  output logic                 flag_dz,
  output logic                 flag_ovf,
  output logic                 flag_unf
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int QW = MAN_W + 3;
  localparam int RW = MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam int LW = $clog2(SW + 1);
  localparam int CW = $clog2(QW);
  localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EZERO = '0;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ROUND, S_DONE} state_t;
  state_t r_state, w_next;

  logic                 r_sign;
  logic signed [EW-1:0] r_exp;
  logic [RW-1:0]        r_rem;
  logic [SW-1:0]        r_div;
  logic [QW-1:0]        r_quo;
  logic [CW-1:0]        r_cnt;
  logic [W-1:0]         r_out;
  logic                 r_inv, r_dz, r_ovf, r_unf;

  function automatic logic [LW-1:0] f_lzc(input logic [SW-1:0] v);
    f_lzc = LW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (v[i]) f_lzc = LW'(SW - 1 - i);
    end
  endfunction

  logic [EXP_W-1:0] w_e1, w_e2;
  logic [MAN_W-1:0] w_f1, w_f2;
  logic w_nan1, w_nan2, w_inf1, w_inf2, w_zero1, w_zero2, w_special, w_sign;
  assign w_e1 = in1[W-2:MAN_W];
  assign w_e2 = in2[W-2:MAN_W];
  assign w_f1 = in1[MAN_W-1:0];
  assign w_f2 = in2[MAN_W-1:0];
  assign w_nan1  = (&w_e1) & (|w_f1);
  assign w_nan2  = (&w_e2) & (|w_f2);
  assign w_inf1  = (&w_e1) & ~(|w_f1);
  assign w_inf2  = (&w_e2) & ~(|w_f2);
  assign w_zero1 = ~(|w_e1) & ~(|w_f1);
  assign w_zero2 = ~(|w_e2) & ~(|w_f2);
  assign w_special = w_nan1 | w_nan2 | w_inf1 | w_inf2 | w_zero1 | w_zero2;
  assign w_sign = in1[W-1] ^ in2[W-1];

  // Subnormals: biased exponent behaves as 1, then the leading-zero shift lowers it further
  logic [SW-1:0] w_sig1, w_sig2, w_nsig1, w_nsig2;
  logic [LW-1:0] w_lz1, w_lz2;
  logic signed [EW-1:0] w_x1, w_x2, w_exp;
  assign w_sig1  = {|w_e1, w_f1};
  assign w_sig2  = {|w_e2, w_f2};
  assign w_lz1   = f_lzc(w_sig1);
  assign w_lz2   = f_lzc(w_sig2);
  assign w_nsig1 = w_sig1 << w_lz1;
  assign w_nsig2 = w_sig2 << w_lz2;
  assign w_x1  = $signed(EW'(w_e1 | EXP_W'(~|w_e1))) - $signed(EW'(w_lz1));
  assign w_x2  = $signed(EW'(w_e2 | EXP_W'(~|w_e2))) - $signed(EW'(w_lz2));
  assign w_exp = w_x1 - w_x2 + BIAS;

  logic [W-1:0] w_sp_out;
  logic w_sp_inv, w_sp_dz;
  always_comb begin
    w_sp_out = {w_sign, {(W-1){1'b0}}};
    w_sp_inv = 1'b0;
    w_sp_dz  = 1'b0;
    if (w_nan1 | w_nan2 | (w_zero1 & w_zero2) | (w_inf1 & w_inf2)) begin
      w_sp_out = QNAN;
      w_sp_inv = 1'b1;
    end else if (w_inf1) begin
      w_sp_out = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_zero2) begin
      w_sp_out = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_sp_dz  = 1'b1;
    end
  end

  logic          w_ge;
  logic [RW-1:0] w_sub, w_rem_sel;
  assign w_ge      = r_rem >= {1'b0, r_div};
  assign w_sub     = r_rem - {1'b0, r_div};
  assign w_rem_sel = w_ge ? w_sub : r_rem;

  logic [QW-1:0]        w_qn;
  logic signed [EW-1:0] w_en, w_er;
  logic [SW-1:0]        w_mant;
  logic [SW:0]          w_mr;
  logic [MAN_W-1:0]     w_frac;
  logic                 w_g, w_st, w_rup;
  assign w_qn   = r_quo[QW-1] ? r_quo : {r_quo[QW-2:0], 1'b0};
  assign w_en   = r_quo[QW-1] ? r_exp : r_exp - EW'(1);
  assign w_mant = w_qn[QW-1:2];
  assign w_g    = w_qn[1];
  assign w_st   = w_qn[0] | (|r_rem);
  assign w_rup  = w_g & (w_st | w_mant[0]);
  assign w_mr   = {1'b0, w_mant} + {{SW{1'b0}}, w_rup};
  assign w_er   = w_mr[SW] ? w_en + EW'(1) : w_en;
  assign w_frac = w_mr[SW] ? w_mr[MAN_W:1] : w_mr[MAN_W-1:0];

  logic [W-1:0] w_rnd_out;
  logic w_rnd_ovf, w_rnd_unf;
  always_comb begin
    w_rnd_out = {r_sign, w_er[EXP_W-1:0], w_frac};
    w_rnd_ovf = 1'b0;
    w_rnd_unf = 1'b0;
    if (w_er >= EMAX) begin
      w_rnd_out = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_rnd_ovf = 1'b1;
    end else if (w_er <= EZERO) begin
      w_rnd_out = {r_sign, {(W-1){1'b0}}};
      w_rnd_unf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = w_special ? S_DONE : S_CALC;
      end
      S_CALC:  if (r_cnt == CW'(QW - 1)) w_next = S_ROUND;
      S_ROUND: w_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign <= 1'b0;
      r_exp  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_out  <= '0;
      r_inv  <= 1'b0;
      r_dz   <= 1'b0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_sign <= w_sign;
          r_exp  <= w_exp;
          r_rem  <= {1'b0, w_nsig1};
          r_div  <= w_nsig2;
          r_quo  <= '0;
          r_cnt  <= '0;
          if (w_special) begin
            r_out <= w_sp_out;
            r_inv <= w_sp_inv;
            r_dz  <= w_sp_dz;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_sel << 1;
          r_quo <= {r_quo[QW-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
        end
        S_ROUND: begin
          r_out <= w_rnd_out;
          r_inv <= 1'b0;
          r_dz  <= 1'b0;
          r_ovf <= w_rnd_ovf;
          r_unf <= w_rnd_unf;
        end
        default: ;
      endcase
    end
  end

  assign out          = r_out;
  assign flag_invalid = r_inv;
  assign flag_dz      = r_dz;
  assign flag_ovf     = r_ovf;
  assign flag_unf     = r_unf;

endmodule

// File: tb/tb_fp_div_seq.sv
// tb/tb_fp_div_seq.sv - randomized and directed bench for fp_div_seq against an exact rational model
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        in_ready, out_valid;
  logic [31:0] out;
  logic        flag_invalid, flag_dz, flag_ovf, flag_unf;
  logic [3:0]  fl;

  int n_checks = 0;
  int n_fail = 0;

  fp_div_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .flag_invalid(flag_invalid), .flag_dz(flag_dz), .flag_ovf(flag_ovf), .flag_unf(flag_unf)
  );

  assign fl = {flag_invalid, flag_dz, flag_ovf, flag_unf};

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
  } vec_t;

  // Exact quotient of the two significand integers, rounded to nearest-even; flags as {inv,dz,ovf,unf}
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f, output bit sp);
    int ea, eb, xa, xb, e, be;
    longint ma, mb, n, q, rm;
    bit s, st, g, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    s = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = longint'(a[22:0]);
    mb = longint'(b[22:0]);
    a_nan = (ea == 255) && (ma != 0);
    b_nan = (eb == 255) && (mb != 0);
    a_inf = (ea == 255) && (ma == 0);
    b_inf = (eb == 255) && (mb == 0);
    a_zero = (ea == 0) && (ma == 0);
    b_zero = (eb == 0) && (mb == 0);
    f = 4'b0000;
    sp = 1'b1;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      r = 32'h7FC00000;
      f = 4'b1000;
      return;
    end
    if (a_inf) begin
      r = {s, 8'hFF, 23'h0};
      return;
    end
    if (b_zero) begin
      r = {s, 8'hFF, 23'h0};
      f = 4'b0100;
      return;
    end
    if (a_zero || b_inf) begin
      r = {s, 31'h0};
      return;
    end
    sp = 1'b0;
    xa = (ea == 0) ? -149 : ea - 150;
    xb = (eb == 0) ? -149 : eb - 150;
    if (ea != 0) ma = ma + (64'd1 << 23);
    if (eb != 0) mb = mb + (64'd1 << 23);
    while (ma < (64'd1 << 23)) begin ma = ma << 1; xa = xa - 1; end
    while (mb < (64'd1 << 23)) begin mb = mb << 1; xb = xb - 1; end
    n  = ma << 26;
    q  = n / mb;
    rm = n % mb;
    st = (rm != 0);
    e  = xa - xb - 26;
    while (q >= (64'd1 << 25)) begin
      st = st | q[0];
      q = q >> 1;
      e = e + 1;
    end
    g = q[0];
    q = q >> 1;
    e = e + 1;
    if (g && (st || q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin q = q >> 1; e = e + 1; end
    be = e + 150;
    if (be >= 255) begin
      r = {s, 8'hFF, 23'h0};
      f = 4'b0010;
    end else if (be <= 0) begin
      r = {s, 31'h0};
      f = 4'b0001;
    end else begin
      r = {s, be[7:0], q[22:0]};
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] x;
    int k;
    x = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0: x[30:0] = 31'h0;
      1: begin
        x[30:23] = 8'hFF;
        if ($urandom_range(0, 1) == 0) x[22:0] = 23'h0;
      end
      2: x[30:23] = 8'h00;
      3: ;
      default: x[30:23] = 8'($urandom_range(64, 190));
    endcase
    return x;
  endfunction

  // Drives one operation with out_ready held high; lat = -1 if no result within the budget
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [3:0] f, output int lat);
    @(negedge clk);
    in1 = a;
    in2 = b;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    r = '0;
    f = '0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        r = out;
        f = fl;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
    end
    n_checks++;
    if (out !== 32'h0 || fl !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: out=%h flags=%b, expected 00000000/0000", out, fl);
    end
    rst_n = 1'b1;
  endtask

  task automatic run_table(input string tag, input vec_t v[$]);
    logic [31:0] r;
    logic [3:0] f;
    int lat;
    foreach (v[i]) begin
      do_op(v[i].a, v[i].b, r, f, lat);
      n_checks++;
      if (r !== v[i].r) begin
        n_fail++;
        $display("FAIL %s[%0d] out: %h/%h got %h, expected %h", tag, i, v[i].a, v[i].b, r, v[i].r);
      end
      n_checks++;
      if (f !== v[i].f) begin
        n_fail++;
        $display("FAIL %s[%0d] flags: got %b, expected %b", tag, i, f, v[i].f);
      end
      n_checks++;
      if (lat != v[i].lat) begin
        n_fail++;
        $display("FAIL %s[%0d] latency: got %0d, expected %0d", tag, i, lat, v[i].lat);
      end
    end
  endtask

  task automatic test_normal();
    vec_t v[$];
    v.push_back('{32'h3FC00000, 32'h40300000, 32'h3F0BA2E9, 4'b0000, 28});
    v.push_back('{32'hC0600000, 32'hBFA00000, 32'h40333333, 4'b0000, 28});
    v.push_back('{32'h00400000, 32'h00200000, 32'h40000000, 4'b0000, 28});
    v.push_back('{32'h00C00000, 32'h00A00000, 32'h3F99999A, 4'b0000, 28});
    run_table("normal", v);
  endtask

  task automatic test_specials();
    vec_t v[$];
    v.push_back('{32'hC4FC74CD, 32'h00000000, 32'hFF800000, 4'b0100, 1});
    v.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1});
    v.push_back('{32'h7F800000, 32'h00000000, 32'h7F800000, 4'b0000, 1});
    v.push_back('{32'h4128A3D7, 32'hFF800000, 32'h80000000, 4'b0000, 1});
    v.push_back('{32'h4128A3D7, 32'hFF800001, 32'h7FC00000, 4'b1000, 1});
    run_table("special", v);
  endtask

  task automatic test_range();
    vec_t v[$];
    v.push_back('{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 28});
    v.push_back('{32'h00800000, 32'h41000000, 32'h00000000, 4'b0001, 28});
    run_table("range", v);
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, er;
    logic [3:0] f, ef;
    bit sp;
    int lat;
    for (int i = 0; i < 150; i++) begin
      a = rand_op();
      b = rand_op();
      ref_div(a, b, er, ef, sp);
      do_op(a, b, r, f, lat);
      n_checks++;
      if (r !== er || f !== ef) begin
        n_fail++;
        $display("FAIL random[%0d] %h/%h: got %h flags %b, expected %h flags %b", i, a, b, r, f, er, ef);
      end
      n_checks++;
      if (lat != (sp ? 1 : 28)) begin
        n_fail++;
        $display("FAIL random[%0d] latency: got %0d, expected %0d", i, lat, sp ? 1 : 28);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] hold_out;
    logic [3:0] hold_fl;
    int lat;
    bit bad;
    @(negedge clk);
    in1 = 32'h3FC00000;
    in2 = 32'h40300000;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 5) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_in_ready: got %b, expected 0", in_ready);
        end
      end
      if (out_valid) begin lat = i; break; end
    end
    hold_out = out;
    hold_fl = fl;
    n_checks++;
    if (lat != 28 || hold_out !== 32'h3F0BA2E9 || hold_fl !== 4'b0000) begin
      n_fail++;
      $display("FAIL bp_result: lat %0d out %h flags %b, expected 28 3f0ba2e9 0000", lat, hold_out, hold_fl);
    end
    in1 = 32'h40000000;
    in2 = 32'h3F800000;
    in_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out !== hold_out || fl !== hold_fl || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL bp_hold: out %h flags %b valid %b ready %b, expected %h %b 1 0", out, fl, out_valid, in_ready, hold_out, hold_fl);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [31:0] r;
    logic [3:0] f;
    int lat;
    bit stale;
    @(negedge clk);
    in1 = 32'h3FC00000;
    in2 = 32'h40300000;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL calc_handshake: in_ready=%b out_valid=%b, expected 0/0", in_ready, out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async: in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    n_checks++;
    if (stale) begin
      n_fail++;
      $display("FAIL midreset_stale: out_valid seen 1, expected 0 after abandoned operation");
    end
    do_op(32'h3FC00000, 32'h40300000, r, f, lat);
    n_checks++;
    if (r !== 32'h3F0BA2E9 || f !== 4'b0000 || lat != 28) begin
      n_fail++;
      $display("FAIL midreset_rerun: out %h flags %b lat %0d, expected 3f0ba2e9 0000 28", r, f, lat);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal();
    test_specials();
    test_range();
    test_backpressure();
    test_random();
    test_reset_mid_calc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
